// File: rtl/enc4to2_pipe.sv
// enc4to2_pipe: registered 4-to-2 priority encoder with valid/ready on both
// sides. The winning line index of an accepted word appears one cycle later,
// along with flags for zero and multi-hot words. Error words are counted in
// a saturating counter that can be cleared synchronously.
//
// Ports:
//   clk        clock, all state updates on the rising edge
//   rst_n      asynchronous active-low reset
//   in_valid   upstream presents in_y
//   in_ready   block can accept this cycle (combinational)
//   in_y       4-bit line vector to encode
//   out_valid  out_code/out_zero/out_multi valid
//   out_ready  downstream accepts this cycle
//   out_code   index of the winning line
//   out_zero   accepted word had no bit set
//   out_multi  accepted word had more than one bit set
//   clr_err    synchronous clear of err_count
//   err_count  saturating count of accepted zero or multi-hot words
//
// state   | meaning
// --------+-------------------------------------------
// S_EMPTY | output register holds nothing, out_valid=0
// S_FULL  | output register holds a result, out_valid=1
module enc4to2_pipe #(
  parameter bit PRIORITY_HIGH = 1'b1,
  parameter int ERR_CNT_W     = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [3:0]           in_y,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [1:0]           out_code,
  output logic                 out_zero,
  output logic                 out_multi,
  input  logic                 clr_err,
  output logic [ERR_CNT_W-1:0] err_count
);

  typedef enum logic {S_EMPTY = 1'b0, S_FULL = 1'b1} state_t;

  localparam logic [ERR_CNT_W-1:0] ERR_MAX = {ERR_CNT_W{1'b1}};

  state_t     state_q;
  state_t     state_d;
  logic       accept;
  logic [1:0] code_d;
  logic       zero_d;
  logic       multi_d;

  assign accept = in_valid && in_ready;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_EMPTY: if (accept) state_d = S_FULL;
      S_FULL:  if (out_ready && !accept) state_d = S_EMPTY;
      default: state_d = S_EMPTY;
    endcase
  end

  // Output logic; in_ready lets a new word in while the held one drains
  always_comb begin
    out_valid = (state_q == S_FULL);
    in_ready  = (state_q == S_EMPTY) || out_ready;
  end

  // Encoder; a zero word falls through to code 0 in both priority modes
  always_comb begin
    code_d = 2'd0;
    if (PRIORITY_HIGH) begin
      if (in_y[3])      code_d = 2'd3;
      else if (in_y[2]) code_d = 2'd2;
      else if (in_y[1]) code_d = 2'd1;
      else              code_d = 2'd0;
    end else begin
      if (in_y[0])      code_d = 2'd0;
      else if (in_y[1]) code_d = 2'd1;
      else if (in_y[2]) code_d = 2'd2;
      else if (in_y[3]) code_d = 2'd3;
      else              code_d = 2'd0;
    end
    zero_d  = (in_y == 4'b0000);
    // Clearing the lowest set bit leaves something only if two or more were set
    multi_d = ((in_y & (in_y - 4'd1)) != 4'b0000);
  end

  // Result register, loaded only on accept so it holds under backpressure
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_code  <= 2'd0;
      out_zero  <= 1'b0;
      out_multi <= 1'b0;
    end else if (accept) begin
      out_code  <= code_d;
      out_zero  <= zero_d;
      out_multi <= multi_d;
    end
  end

  // Saturating error counter; clear wins over a same-cycle increment
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_count <= '0;
    end else if (clr_err) begin
      err_count <= '0;
    end else if (accept && (zero_d || multi_d) && (err_count != ERR_MAX)) begin
      err_count <= err_count + ERR_CNT_W'(1);
    end
  end

endmodule
